// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional feature macro: REGFILE_RDREG_EN (registered read data, 1-cycle latency).
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Width of a flat bus carrying n slices of w bits each
  function automatic int packed_w(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port: hardwired zero, then write bypass, then stored value.
module regfile_rd_mux #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRW     = 4,
  parameter int NWR       = 2,
  parameter int ZERO_REG  = 0
) (
  input  logic [ADDRW-1:0]                rd_addr,
  input  logic [DATAWIDTH-1:0]            stored,
  input  logic                            bypass_en,
  input  logic [NWR-1:0]                  wr_en,
  input  logic [NWR-1:0][ADDRW-1:0]       wr_addr,
  input  logic [NWR-1:0][DATAWIDTH-1:0]   wr_data,
  output logic [DATAWIDTH-1:0]            rd_data
);

  // Later ports overwrite earlier matches, so the highest-index match wins
  always_comb begin
    rd_data = stored;
    if (bypass_en) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j] == rd_addr)) rd_data = wr_data[j];
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) rd_data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with sequential bulk-clear engine.
// Optional feature macro: REGFILE_RDREG_EN (registered read data, 1-cycle latency).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 16,
  parameter int ADDRW     = $clog2(NREGS),
  parameter int NRD       = 4,
  parameter int NWR       = 2,
  parameter int ZERO_REG  = 0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [packed_w(NRD, ADDRW)-1:0]       rd_addr,
  output logic [packed_w(NRD, DATAWIDTH)-1:0]   rd_data,
  input  logic [NWR-1:0]                        wr_en,
  input  logic [packed_w(NWR, ADDRW)-1:0]       wr_addr,
  input  logic [packed_w(NWR, DATAWIDTH)-1:0]   wr_data,
  input  logic                                  clr_req,
  output logic                                  clr_busy,
  output logic                                  clr_done
);

  localparam logic [ADDRW-1:0] LAST = ADDRW'(NREGS - 1);

  logic [NREGS-1:0][DATAWIDTH-1:0] regs;
  logic [NRD-1:0][ADDRW-1:0]       ra;
  logic [NWR-1:0][ADDRW-1:0]       wa;
  logic [NWR-1:0][DATAWIDTH-1:0]   wd;
  logic [NRD-1:0][DATAWIDTH-1:0]   rd_comb;

  clr_state_t       state, state_nxt;
  logic [ADDRW-1:0] cnt, cnt_nxt;

  assign ra = rd_addr;
  assign wa = wr_addr;
  assign wd = wr_data;

  // Clear-engine state and sweep address
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear-engine next state; sweep ends after the last entry is zeroed
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);
  // A reset on the final sweep cycle aborts the sweep, so no done pulse
  assign clr_done = (state == CLEAR) && (cnt == LAST) && resetn;

  // Storage: sweep zeroing owns the array in CLEAR; otherwise port writes, highest port last
  always_ff @(posedge clk) begin
    if (!resetn) begin
      regs <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wa[j] == '0))) regs[wa[j]] <= wd[j];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_mux #(
      .DATAWIDTH (DATAWIDTH),
      .ADDRW     (ADDRW),
      .NWR       (NWR),
      .ZERO_REG  (ZERO_REG)
    ) u_rd_mux (
      .rd_addr   (ra[i]),
      .stored    (regs[ra[i]]),
      .bypass_en (state == IDLE),
      .wr_en     (wr_en),
      .wr_addr   (wa),
      .wr_data   (wd),
      .rd_data   (rd_comb[i])
    );
  end

`ifdef REGFILE_RDREG_EN
  logic [NRD-1:0][DATAWIDTH-1:0] rd_q;

  // Capture the combinational read (bypass included) for 1-cycle latency
  always_ff @(posedge clk) begin
    if (!resetn) rd_q <= '0;
    else         rd_q <= rd_comb;
  end

  assign rd_data = rd_q;
`else
  assign rd_data = rd_comb;
`endif

endmodule
